// File: rtl/peak_pkg.sv
// Shared types and the exact fractional compare used by the peak capture window.
package peak_pkg;

   localparam int NUM_W  = 60;
   localparam int DEN_W  = 50;
   localparam int TIME_W = 14;
   localparam int PROD_W = NUM_W + DEN_W;

   typedef struct packed {
      logic [NUM_W-1:0] num;
      logic [DEN_W-1:0] den;
   } frac_t;

   // t_stamp stands for the record's time field ("time" is a reserved word)
   typedef struct packed {
      frac_t             yn1;
      frac_t             yn2;
      frac_t             yn3;
      logic [TIME_W-1:0] t_stamp;
   } rec_t;

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      COMMIT
   } state_e;

   // a > b, cross-multiplied so no division is needed; equal fractions are not greater
   function automatic logic gt_frac(frac_t a, frac_t b);
      logic [PROD_W-1:0] lhs;
      logic [PROD_W-1:0] rhs;
      lhs = PROD_W'(a.num) * PROD_W'(b.den);
      rhs = PROD_W'(b.num) * PROD_W'(a.den);
      return lhs > rhs;
   endfunction

endpackage

// File: rtl/peak_rec_fifo.sv
// Single-clock show-ahead FIFO of whole peak records, so the fields always stay aligned.
module peak_rec_fifo
   import peak_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          wr_i,
   input  rec_t          rec_i,
   input  logic          rd_i,
   output rec_t          rec_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o
);

   rec_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          push_w;
   logic          pop_w;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign pop_w   = rd_i & ~empty_o;
   // a pop in the same cycle frees the slot a full FIFO needs
   assign push_w  = wr_i & (~full_o | pop_w);
   // head record is forced to zero when empty so stale data never shows
   assign rec_o   = empty_o ? '0 : mem_q[rd_ptr_q];

   // storage, pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push_w) begin
            mem_q[wr_ptr_q] <= rec_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_w) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + (AW+1)'(push_w) - (AW+1)'(pop_w);
      end
   end

endmodule

// File: rtl/peak_capture_window.sv
// Picks one peak per DETECTION window from the Y = NUM/DEN stream and queues
// its three-sample neighbourhood plus corrected timestamp for the NIOS.
//
//   state  | meaning
//   IDLE   | waiting for DETECTION; entry to TRACK latches MODE, clears candidate
//   TRACK  | window open, judging each fresh sample S1 against its neighbours
//   COMMIT | window closed, candidate (if any) is written to the FIFO
module peak_capture_window
   import peak_pkg::*;
#(
   parameter int TAPS  = 65,
   parameter int DEPTH = 8
) (
   input  logic                   SYS_CLK,
   input  logic                   RST_N,
   input  logic                   CLK_EN,
   input  logic                   DETECTION,
   input  logic [NUM_W-1:0]       Yn_NUM,
   input  logic [DEN_W-1:0]       Yn_DEN,
   input  logic [TIME_W-1:0]      TIMER,
   input  logic                   MODE,
   input  logic                   NIOS_RD_PEAK,
   input  logic                   CLR_OVF,
   output logic                   VALID_PEAK_FOUND,
   output logic [NUM_W+DEN_W-1:0] PEAK_YN1_OUTPUT,
   output logic [NUM_W+DEN_W-1:0] PEAK_YN2_OUTPUT,
   output logic [NUM_W+DEN_W-1:0] PEAK_YN3_OUTPUT,
   output logic [TIME_W-1:0]      PEAK_TIME_OUTPUT,
   output logic                   FIFO_FULL,
   output logic                   OVERFLOW,
   output logic [7:0]             DROP_COUNT
);

   localparam int AW = $clog2(DEPTH);

   frac_t             s0_q, s1_q, s2_q;
   logic [TIME_W-1:0] ts_q;
   logic              upd_q;
   state_e            state_q, state_d;
   logic              mode_q, mode_d;
   logic              have_q, have_d;
   rec_t              best_q, best_d;
   logic              local_w;
   logic              wr_w;
   logic              drop_w;
   logic              ovf_q;
   logic [7:0]        drop_cnt_q;
   rec_t              head_w;
   logic              fifo_full_w;
   logic              fifo_empty_w;
   logic [AW:0]       fifo_cnt_w;
   rec_t              cand_w;

   assign local_w = gt_frac(s1_q, s0_q) & gt_frac(s1_q, s2_q) & DETECTION & upd_q;

   // TS is the newest sample's time, so the candidate S1 sits at TS-1,
   // then back off the filter group delay of TAPS-1; wraps modulo 2^TIME_W
   assign cand_w = '{yn1: s0_q, yn2: s1_q, yn3: s2_q,
                     t_stamp: ts_q - TIME_W'(TAPS)};

   // three-sample window and the one-cycle-late evaluate strobe
   always_ff @(posedge SYS_CLK or negedge RST_N) begin
      if (!RST_N) begin
         s0_q  <= '0;
         s1_q  <= '0;
         s2_q  <= '0;
         ts_q  <= '0;
         upd_q <= 1'b0;
      end else begin
         if (CLK_EN) begin
            s2_q <= '{num: Yn_NUM, den: Yn_DEN};
            s1_q <= s2_q;
            s0_q <= s1_q;
            ts_q <= TIMER;
         end
         upd_q <= CLK_EN;
      end
   end

   // window FSM state and candidate registers
   always_ff @(posedge SYS_CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         have_q  <= 1'b0;
         best_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         have_q  <= have_d;
         best_q  <= best_d;
      end
   end

   // next state, candidate selection and the commit strobe
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      have_d  = have_q;
      best_d  = best_q;
      wr_w    = 1'b0;
      case (state_q)
         IDLE: begin
            if (DETECTION) begin
               state_d = TRACK;
               mode_d  = MODE;
               have_d  = 1'b0;
               best_d  = '0;
            end
         end
         TRACK: begin
            if (!DETECTION) begin
               state_d = COMMIT;
            end else if (local_w && (!have_q || (!mode_q && gt_frac(s1_q, best_q.yn2)))) begin
               best_d = cand_w;
               have_d = 1'b1;
            end
         end
         COMMIT: begin
            wr_w    = have_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // a commit into a full FIFO is lost unless a pop frees the slot this cycle
   assign drop_w = wr_w & fifo_full_w & ~NIOS_RD_PEAK;

   // sticky overflow flag and saturating drop counter; clear wins over a drop
   always_ff @(posedge SYS_CLK or negedge RST_N) begin
      if (!RST_N) begin
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else if (CLR_OVF) begin
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else if (drop_w) begin
         ovf_q <= 1'b1;
         if (drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
         end
      end
   end

   peak_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (SYS_CLK),
      .rst_n_i (RST_N),
      .wr_i    (wr_w),
      .rec_i   (best_q),
      .rd_i    (NIOS_RD_PEAK),
      .rec_o   (head_w),
      .full_o  (fifo_full_w),
      .empty_o (fifo_empty_w),
      .count_o (fifo_cnt_w)
   );

   assign VALID_PEAK_FOUND = ~fifo_empty_w;
   assign FIFO_FULL        = (fifo_cnt_w == (AW+1)'(DEPTH));
   assign PEAK_YN1_OUTPUT  = head_w.yn1;
   assign PEAK_YN2_OUTPUT  = head_w.yn2;
   assign PEAK_YN3_OUTPUT  = head_w.yn3;
   assign PEAK_TIME_OUTPUT = head_w.t_stamp;
   assign OVERFLOW         = ovf_q;
   assign DROP_COUNT       = drop_cnt_q;

endmodule

// File: tb/tb_peak_capture_window.sv
// Randomised and directed bench for peak_capture_window against a behavioural model.
module tb_peak_capture_window;

   localparam int TAPS  = 65;
   localparam int DEPTH = 8;

   logic          SYS_CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          CLK_EN = 1'b0;
   logic          DETECTION = 1'b0;
   logic [59:0]   Yn_NUM = '0;
   logic [49:0]   Yn_DEN = '0;
   logic [13:0]   TIMER = '0;
   logic          MODE = 1'b0;
   logic          NIOS_RD_PEAK = 1'b0;
   logic          CLR_OVF = 1'b0;
   logic          VALID_PEAK_FOUND;
   logic [109:0]  PEAK_YN1_OUTPUT, PEAK_YN2_OUTPUT, PEAK_YN3_OUTPUT;
   logic [13:0]   PEAK_TIME_OUTPUT;
   logic          FIFO_FULL, OVERFLOW;
   logic [7:0]    DROP_COUNT;

   peak_capture_window #(.TAPS(TAPS), .DEPTH(DEPTH)) dut (
      .SYS_CLK          (SYS_CLK),
      .RST_N            (RST_N),
      .CLK_EN           (CLK_EN),
      .DETECTION        (DETECTION),
      .Yn_NUM           (Yn_NUM),
      .Yn_DEN           (Yn_DEN),
      .TIMER            (TIMER),
      .MODE             (MODE),
      .NIOS_RD_PEAK     (NIOS_RD_PEAK),
      .CLR_OVF          (CLR_OVF),
      .VALID_PEAK_FOUND (VALID_PEAK_FOUND),
      .PEAK_YN1_OUTPUT  (PEAK_YN1_OUTPUT),
      .PEAK_YN2_OUTPUT  (PEAK_YN2_OUTPUT),
      .PEAK_YN3_OUTPUT  (PEAK_YN3_OUTPUT),
      .PEAK_TIME_OUTPUT (PEAK_TIME_OUTPUT),
      .FIFO_FULL        (FIFO_FULL),
      .OVERFLOW         (OVERFLOW),
      .DROP_COUNT       (DROP_COUNT)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   typedef struct {
      logic [109:0] y1, y2, y3;
      logic [13:0]  t;
   } mrec_t;

   mrec_t        mq[$];
   logic [109:0] hist [3];     // hist[0] oldest, hist[2] newest sample
   logic [13:0]  last_t;
   bit           judged_pending;
   int           win;          // 0 closed, 1 open, 2 just closed
   bit           first_rule;
   bit           have;
   mrec_t        best;
   bit           m_ovf;
   int           m_drops;

   function automatic bit frac_gt(logic [109:0] a, logic [109:0] b);
      logic [127:0] l, r;
      l = 128'(a[109:50]) * 128'(b[49:0]);
      r = 128'(b[109:50]) * 128'(a[49:0]);
      return l > r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) hist[i] = '0;
      last_t = '0;
      judged_pending = 0;
      win = 0;
      first_rule = 0;
      have = 0;
      best = '{default: '0};
      mq.delete();
      m_ovf = 0;
      m_drops = 0;
   endtask

   task automatic model_update(input bit en, input bit det, input logic [109:0] y,
                               input logic [13:0] t, input bit md, input bit rd, input bit clr);
      bit    pop, push, drop, peak;
      int    sz;
      mrec_t r;
      sz   = mq.size();
      pop  = rd && (sz > 0);
      push = (win == 2) && have;
      drop = 0;
      if (pop) void'(mq.pop_front());
      if (push) begin
         if (sz == DEPTH && !pop) drop = 1;
         else mq.push_back(best);
      end
      if (clr) begin
         m_ovf = 0;
         m_drops = 0;
      end else if (drop) begin
         m_ovf = 1;
         if (m_drops < 255) m_drops++;
      end
      peak = judged_pending && det && frac_gt(hist[1], hist[0]) && frac_gt(hist[1], hist[2]);
      if (win == 0) begin
         if (det) begin
            win = 1;
            first_rule = md;
            have = 0;
         end
      end else if (win == 1) begin
         if (!det) win = 2;
         else if (peak && (!have || (!first_rule && frac_gt(hist[1], best.y2)))) begin
            r.y1 = hist[0];
            r.y2 = hist[1];
            r.y3 = hist[2];
            r.t  = 14'(int'(last_t) - 1 - (TAPS - 1));
            best = r;
            have = 1;
         end
      end else begin
         win = 0;
      end
      if (en) begin
         hist[0] = hist[1];
         hist[1] = hist[2];
         hist[2] = y;
         last_t  = t;
      end
      judged_pending = en;
   endtask

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      mrec_t h;
      h = '{default: '0};
      if (mq.size() > 0) h = mq[0];
      check_val("valid", VALID_PEAK_FOUND, mq.size() > 0);
      check_val("full", FIFO_FULL, mq.size() == DEPTH);
      check_val("ovf", OVERFLOW, m_ovf);
      check_val("drops", DROP_COUNT, m_drops);
      check_val("yn1", PEAK_YN1_OUTPUT, h.y1);
      check_val("yn2", PEAK_YN2_OUTPUT, h.y2);
      check_val("yn3", PEAK_YN3_OUTPUT, h.y3);
      check_val("time", PEAK_TIME_OUTPUT, h.t);
   endtask

   // ---------------- stimulus helpers ----------------
   bit cur_mode = 0;

   task automatic step(input bit en, input bit det, input logic [59:0] n, input logic [49:0] d,
                       input logic [13:0] t, input bit rd, input bit clr);
      CLK_EN = en; DETECTION = det; Yn_NUM = n; Yn_DEN = d; TIMER = t;
      MODE = cur_mode; NIOS_RD_PEAK = rd; CLR_OVF = clr;
      @(posedge SYS_CLK);
      model_update(en, det, {n, d}, t, cur_mode, rd, clr);
      #1;
      check_outputs();
   endtask

   task automatic feed(input logic [59:0] n, input logic [49:0] d, input logic [13:0] t);
      step(1, 1, n, d, t, 0, 0);
   endtask

   task automatic prime();
      for (int i = 0; i < 3; i++) step(1, 0, 60'd0, 50'd1, 14'd0, 0, 0);
   endtask

   task automatic open_win(input bit md);
      cur_mode = md;
      step(0, 1, '0, '0, '0, 0, 0);
   endtask

   // extra det-high cycle judges the last fed sample, then fall, commit, settle
   task automatic close_win(input bit rd_on_commit);
      step(0, 1, '0, '0, '0, 0, 0);
      step(0, 0, '0, '0, '0, 0, 0);
      step(0, 0, '0, '0, '0, rd_on_commit, 0);
      step(0, 0, '0, '0, '0, 0, 0);
   endtask

   task automatic pop_one();
      step(0, 0, '0, '0, '0, 1, 0);
   endtask

   task automatic peak_window(input logic [13:0] t0, input bit rd_on_commit);
      open_win(0);
      feed(60'd0, 50'd1, t0);
      feed(60'd5, 50'd1, t0 + 14'd1);
      feed(60'd0, 50'd1, t0 + 14'd2);
      close_win(rd_on_commit);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      bit det_r;
      model_reset();
      repeat (2) @(posedge SYS_CLK);
      #1;
      check_val("rst_valid", VALID_PEAK_FOUND, 0);
      check_val("rst_full", FIFO_FULL, 0);
      check_val("rst_ovf", OVERFLOW, 0);
      check_val("rst_drops", DROP_COUNT, 0);
      check_val("rst_yn2", PEAK_YN2_OUTPUT, 0);
      check_val("rst_time", PEAK_TIME_OUTPUT, 0);
      RST_N = 1'b1;

      // absolute peak
      prime(); open_win(0);
      feed(60'd1, 50'd1, 14'd100); feed(60'd3, 50'd1, 14'd101); feed(60'd2, 50'd1, 14'd102);
      feed(60'd5, 50'd1, 14'd103); feed(60'd4, 50'd1, 14'd104); feed(60'd1, 50'd1, 14'd105);
      close_win(0);
      check_val("abs_valid", VALID_PEAK_FOUND, 1);
      check_val("abs_yn1", PEAK_YN1_OUTPUT, {60'd2, 50'd1});
      check_val("abs_yn2", PEAK_YN2_OUTPUT, {60'd5, 50'd1});
      check_val("abs_yn3", PEAK_YN3_OUTPUT, {60'd4, 50'd1});
      check_val("abs_time", PEAK_TIME_OUTPUT, 14'd39);
      pop_one();
      check_val("abs_popped", VALID_PEAK_FOUND, 0);

      // first local peak
      prime(); open_win(1);
      feed(60'd1, 50'd1, 14'd100); feed(60'd3, 50'd1, 14'd101); feed(60'd2, 50'd1, 14'd102);
      feed(60'd5, 50'd1, 14'd103); feed(60'd4, 50'd1, 14'd104); feed(60'd1, 50'd1, 14'd105);
      close_win(0);
      check_val("first_yn2", PEAK_YN2_OUTPUT, {60'd3, 50'd1});
      check_val("first_time", PEAK_TIME_OUTPUT, 14'd37);
      pop_one();

      // fractional compare
      prime(); open_win(0);
      feed(60'd2, 50'd4, 14'd200); feed(60'd3, 50'd5, 14'd201); feed(60'd1, 50'd2, 14'd202);
      close_win(0);
      check_val("frac_yn2", PEAK_YN2_OUTPUT, {60'd3, 50'd5});
      check_val("frac_time", PEAK_TIME_OUTPUT, 14'd137);
      pop_one();

      // equal fractions are not greater
      prime(); open_win(0);
      feed(60'd1, 50'd2, 14'd300); feed(60'd2, 50'd4, 14'd301); feed(60'd1, 50'd2, 14'd302);
      close_win(0);
      check_val("equal_none", VALID_PEAK_FOUND, 0);

      // monotonic rise
      prime(); open_win(0);
      for (int i = 1; i <= 5; i++) feed(60'(i), 50'd1, 14'(400 + i));
      close_win(0);
      check_val("mono_none", VALID_PEAK_FOUND, 0);

      // overflow: eight fill, ninth drops
      for (int w = 0; w < 8; w++) peak_window(14'(500 + 10 * w), 0);
      check_val("ovf_full8", FIFO_FULL, 1);
      check_val("ovf_none_yet", OVERFLOW, 0);
      peak_window(14'd600, 0);
      check_val("ovf_set", OVERFLOW, 1);
      check_val("ovf_drops1", DROP_COUNT, 1);
      step(0, 0, '0, '0, '0, 0, 1);
      check_val("ovf_cleared", OVERFLOW, 0);
      // commit coinciding with a pop is accepted
      peak_window(14'd700, 1);
      check_val("pop_commit_drops", DROP_COUNT, 0);
      check_val("pop_commit_full", FIFO_FULL, 1);
      for (int i = 0; i < DEPTH; i++) pop_one();
      check_val("drained", VALID_PEAK_FOUND, 0);
      pop_one();

      // timestamp wrap: TS=10 when the peak is judged
      prime(); open_win(0);
      feed(60'd0, 50'd1, 14'd8); feed(60'd7, 50'd1, 14'd9); feed(60'd0, 50'd1, 14'd10);
      close_win(0);
      check_val("wrap_time", PEAK_TIME_OUTPUT, 14'd16329);
      pop_one();

      // reset mid-window discards the candidate
      prime(); open_win(0);
      feed(60'd0, 50'd1, 14'd20); feed(60'd9, 50'd1, 14'd21); feed(60'd0, 50'd1, 14'd22);
      RST_N = 1'b0;
      @(posedge SYS_CLK);
      #1;
      check_val("midrst_valid", VALID_PEAK_FOUND, 0);
      check_val("midrst_yn2", PEAK_YN2_OUTPUT, 0);
      check_val("midrst_time", PEAK_TIME_OUTPUT, 0);
      RST_N = 1'b1;
      model_reset();
      feed(60'd1, 50'd1, 14'd30); feed(60'd2, 50'd1, 14'd31); feed(60'd3, 50'd1, 14'd32);
      close_win(0);
      check_val("midrst_norec", VALID_PEAK_FOUND, 0);

      // randomised traffic
      det_r = 0;
      for (int c = 0; c < 3000; c++) begin
         logic [59:0] n;
         logic [49:0] d;
         if ($urandom_range(0, 7) == 0) det_r = ~det_r;
         if ($urandom_range(0, 9) == 0) begin
            n = {$urandom, $urandom};
            d = 50'({$urandom, $urandom});
            if (d == '0) d = 50'd1;
         end else begin
            n = 60'($urandom_range(0, 7));
            d = 50'($urandom_range(1, 3));
         end
         cur_mode = $urandom_range(0, 1) == 1;
         step($urandom_range(0, 3) != 0, det_r, n, d, 14'($urandom),
              $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
